// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sigin over a gate window
// of gate_len clkin cycles and publishes the count with a one-cycle valid strobe.
module freq_meter #(
    parameter int unsigned gate_len = 100000000,
    parameter int          cnt_w    = 32
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             sigin,
    output logic [cnt_w-1:0] freq,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        LATCH
    } state_t;

    localparam logic [31:0] GATE_LAST = 32'(gate_len - 1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             sigEdge;
    logic [31:0]      gate_cnt_q, gate_cnt_d;
    logic [cnt_w-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic [cnt_w-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q;
    logic             cntFull;
    logic [cnt_w-1:0] edgeCntNext;
    logic             satNext;

    assign sigEdge = s2_q & ~s3_q;
    assign cntFull = &edge_cnt_q;

    // Saturating count including this cycle's edge; sat marks an edge that was dropped.
    assign edgeCntNext = (sigEdge && !cntFull) ? edge_cnt_q + cnt_w'(1) : edge_cnt_q;
    assign satNext     = sat_q | (sigEdge & cntFull);

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (en) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (!en) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else if (gate_cnt_q == GATE_LAST) begin
                    // The final gate cycle's edge is folded into the published count.
                    state_d    = LATCH;
                    freq_d     = edgeCntNext;
                    ovf_d      = satNext;
                    valid_d    = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + 32'd1;
                    edge_cnt_d = edgeCntNext;
                    sat_d      = satNext;
                end
            end
            LATCH: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                state_d    = en ? GATE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= sigin;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            busy_q     <= (state_d == GATE);
        end
    end

    assign freq  = freq_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign busy  = busy_q;

endmodule
